// File: rtl/memory_map_np_if.sv
// Request/response bundle for the N-port memory map.
// Per-port fields are packed side by side, port p in slice p.
interface memory_map_np_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PORTS  = 2
);
    logic [NUM_PORTS-1:0]              en;
    logic [NUM_PORTS-1:0]              we;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] be;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata;
    logic [NUM_PORTS-1:0]              rvalid;
    logic [NUM_PORTS-1:0]              err;

    modport master (
        output en, we, be, addr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  en, we, be, addr, wdata,
        output rdata, rvalid, err
    );
endinterface

// File: rtl/memory_map_np.sv
// N-port memory map: MMIO registers, a read-only status word and an SRAM
// window behind one decoder, with lowest-port-wins write arbitration.
module memory_map_np #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_PORTS    = 2,
    parameter int NUM_REGS     = 14,
    parameter int REG_STRIDE   = 'h0100,
    parameter int SRAM_BASE    = 'h1000,
    parameter int SRAM_DEPTH   = 4096,
    parameter int READ_LATENCY = 1
) (
    input logic            clk,
    input logic            rst,
    memory_map_np_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int NP = NUM_PORTS;
    localparam int NB = DW / 8;
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SW = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
    localparam logic [AW-1:0] STAT_ADDR = AW'(NUM_REGS * REG_STRIDE);

    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] mem_q  [SRAM_DEPTH];
    logic [15:0]   coll_cnt_q;

    logic [AW-1:0] a    [NP];
    logic [AW-1:0] ridx [NP];
    logic [AW-1:0] soff [NP];
    logic [NP-1:0] is_reg, is_stat, is_sram;
    logic [NP-1:0] wr_ok, lose, wr_go, err_d;
    logic [DW-1:0] rd_d [NP];
    logic          coll;

    // Offsets are compared at full width so out-of-window addresses
    // cannot alias into the array through truncation.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            a[p]       = bus.addr[p*AW +: AW];
            ridx[p]    = a[p] / AW'(REG_STRIDE);
            soff[p]    = a[p] - AW'(SRAM_BASE);
            is_reg[p]  = (a[p] % AW'(REG_STRIDE) == '0)
                         && (ridx[p] < AW'(NUM_REGS));
            is_stat[p] = (a[p] == STAT_ADDR);
            is_sram[p] = (soff[p] < AW'(SRAM_DEPTH))
                         && !is_reg[p] && !is_stat[p];
        end
    end

    always_comb begin
        lose = '0;
        for (int p = 0; p < NP; p++) begin
            wr_ok[p] = bus.en[p] & bus.we[p] & (is_reg[p] | is_sram[p]);
        end
        for (int p = 0; p < NP; p++) begin
            for (int q = 0; q < NP; q++) begin
                if (q < p && wr_ok[q] && wr_ok[p] && a[q] == a[p]) begin
                    lose[p] = 1'b1;
                end
            end
        end
        wr_go = wr_ok & ~lose;
        coll  = |lose;
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            unique case (1'b1)
                is_reg[p]:  rd_d[p] = regs_q[ridx[p][RW-1:0]];
                is_stat[p]: rd_d[p] = DW'(coll_cnt_q);
                is_sram[p]: rd_d[p] = mem_q[soff[p][SW-1:0]];
                default:    rd_d[p] = '0;
            endcase
            err_d[p] = bus.we[p] ? ~(is_reg[p] | is_sram[p])
                                 : ~(is_reg[p] | is_stat[p] | is_sram[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            coll_cnt_q <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_go[p] && is_reg[p] && bus.be[p*NB+b]) begin
                        regs_q[ridx[p][RW-1:0]][8*b +: 8] <=
                            bus.wdata[p*DW+8*b +: 8];
                    end
                end
            end
            if (coll && coll_cnt_q != 16'hFFFF) begin
                coll_cnt_q <= coll_cnt_q + 16'd1;
            end
        end
    end

    // SRAM storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_go[p] && is_sram[p] && bus.be[p*NB+b]) begin
                    mem_q[soff[p][SW-1:0]][8*b +: 8] <=
                        bus.wdata[p*DW+8*b +: 8];
                end
            end
        end
    end

    logic [DW-1:0] s1_data_q [NP];
    logic [NP-1:0] s1_vld_q, s1_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                s1_data_q[p] <= '0;
            end
            s1_vld_q <= '0;
            s1_err_q <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                s1_vld_q[p] <= bus.en[p] & ~bus.we[p];
                s1_err_q[p] <= bus.en[p] & err_d[p];
                if (bus.en[p] && !bus.we[p]) begin
                    s1_data_q[p] <= rd_d[p];
                end
            end
        end
    end

    logic [DW-1:0] out_data [NP];
    logic [NP-1:0] out_vld, out_err;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DW-1:0] s2_data_q [NP];
        logic [NP-1:0] s2_vld_q, s2_err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int p = 0; p < NP; p++) begin
                    s2_data_q[p] <= '0;
                end
                s2_vld_q <= '0;
                s2_err_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                s2_err_q <= s1_err_q;
                for (int p = 0; p < NP; p++) begin
                    if (s1_vld_q[p]) begin
                        s2_data_q[p] <= s1_data_q[p];
                    end
                end
            end
        end

        assign out_data = s2_data_q;
        assign out_vld  = s2_vld_q;
        assign out_err  = s2_err_q;
    end else begin : g_lat1
        assign out_data = s1_data_q;
        assign out_vld  = s1_vld_q;
        assign out_err  = s1_err_q;
    end

    for (genvar p = 0; p < NP; p++) begin : g_pack
        assign bus.rdata[p*DW +: DW] = out_data[p];
    end
    assign bus.rvalid = out_vld;
    assign bus.err    = out_err;
endmodule

// File: tb/tb_memory_map_np.sv
// Directed bench: one 2-port latency-1 map and one 4-port latency-2 map
// driven with the same vectors and checked against hand-computed values.
module tb_memory_map_np;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errs = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_map_np_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_PORTS(2)) bus1();
    memory_map_np_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_PORTS(4)) bus2();

    memory_map_np #(.NUM_PORTS(2), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    memory_map_np #(.NUM_PORTS(4), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        int          at;
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t        q [8][$];
    logic [31:0] last [8];
    int          lat [2] = '{1, 2};
    int          np  [2] = '{2, 4};

    logic [31:0] o_d [8];
    logic        o_v [8];
    logic        o_e [8];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            o_d[k] = '0;
            o_v[k] = 1'b0;
            o_e[k] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            o_d[p] = bus1.rdata[p*32 +: 32];
            o_v[p] = bus1.rvalid[p];
            o_e[p] = bus1.err[p];
        end
        for (int p = 0; p < 4; p++) begin
            o_d[4+p] = bus2.rdata[p*32 +: 32];
            o_v[4+p] = bus2.rvalid[p];
            o_e[4+p] = bus2.err[p];
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(string s, int d, int p);
        return $sformatf("%s.dut%0d.p%0d", s, d + 1, p);
    endfunction

    task automatic clr();
        bus1.en = '0; bus1.we = '0; bus1.be = '0;
        bus1.addr = '0; bus1.wdata = '0;
        bus2.en = '0; bus2.we = '0; bus2.be = '0;
        bus2.addr = '0; bus2.wdata = '0;
    endtask

    task automatic put(int p, logic w, logic [3:0] b,
                       logic [15:0] a, logic [31:0] x);
        if (p < 2) begin
            bus1.en[p] = 1'b1; bus1.we[p] = w;
            bus1.be[p*4 +: 4] = b; bus1.addr[p*16 +: 16] = a;
            bus1.wdata[p*32 +: 32] = x;
        end
        bus2.en[p] = 1'b1; bus2.we[p] = w;
        bus2.be[p*4 +: 4] = b; bus2.addr[p*16 +: 16] = a;
        bus2.wdata[p*32 +: 32] = x;
    endtask

    task automatic want(int p, logic v, logic e, logic [31:0] x);
        exp_t t;
        for (int d = 0; d < 2; d++) begin
            if (p < np[d]) begin
                t.at = cyc + lat[d];
                t.v = v;
                t.e = e;
                t.d = x;
                q[d*4+p].push_back(t);
            end
        end
    endtask

    task automatic rd(int p, logic [15:0] a, logic [31:0] x, logic e = 1'b0);
        put(p, 1'b0, 4'h0, a, 32'h0);
        want(p, 1'b1, e, x);
    endtask

    task automatic wr(int p, logic [15:0] a, logic [3:0] b,
                      logic [31:0] x, logic e = 1'b0);
        put(p, 1'b1, b, a, x);
        if (e) want(p, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic flush();
        for (int k = 0; k < 8; k++) q[k].delete();
    endtask

    exp_t mx;
    int   mk;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < np[d]; p++) begin
                mk = d * 4 + p;
                if (rst) begin
                    check(tg("rst", d, p), {o_v[mk], o_e[mk], o_d[mk]}, 64'h0);
                    last[mk] = '0;
                end else if (q[mk].size() > 0 && q[mk][0].at == cyc) begin
                    mx = q[mk].pop_front();
                    check(tg("resp", d, p), {o_v[mk], o_e[mk]}, {mx.v, mx.e});
                    if (mx.v) begin
                        check(tg("data", d, p), o_d[mk], mx.d);
                        last[mk] = mx.d;
                    end else begin
                        check(tg("hold", d, p), o_d[mk], last[mk]);
                    end
                end else begin
                    check(tg("idle", d, p), {o_v[mk], o_e[mk]}, 2'b00);
                    check(tg("hold", d, p), o_d[mk], last[mk]);
                end
            end
        end
    end

    initial begin
        clr();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // traffic in flight when reset hits
        wr(0, 16'h0100, 4'hF, 32'hDEAD0001); step();
        rd(1, 16'h0100, 32'hDEAD0001); step();
        rd(1, 16'h0100, 32'hDEAD0001);
        rst = 1'b1;
        flush();
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 14; k++) begin
            rd(k % 2, 16'(k * 256), 32'h0); step();
        end
        rd(0, 16'h0E00, 32'h0); step();

        // register write/read, back to back
        for (int k = 0; k < 14; k++) begin
            wr(0, 16'(k * 256), 4'hF, 32'hA5A50000 + 32'(k));
            if (k > 0) rd(1, 16'((k - 1) * 256), 32'hA5A50000 + 32'(k - 1));
            step();
        end
        rd(1, 16'h0D00, 32'hA5A5000D); step();

        // byte enables and be==0 no-op
        wr(0, 16'h1004, 4'hF, 32'hFFFFFFFF); step();
        wr(0, 16'h1004, 4'h5, 32'h12345678); step();
        rd(1, 16'h1004, 32'hFF34FF78);
        wr(0, 16'h1004, 4'h0, 32'h0); step();
        rd(0, 16'h1004, 32'hFF34FF78); step();
        for (int p = 0; p < 4; p++) rd(p, 16'h1004, 32'hFF34FF78);
        step();

        // collisions
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 4; p++) begin
                wr(p, 16'h1010, 4'hF, 32'h11 * 32'(p + 1) + 32'(i));
            end
            step();
            rd(0, 16'h1010, 32'h11 + 32'(i));
            rd(1, 16'h0E00, 32'(i + 1));
            step();
        end
        wr(0, 16'h1011, 4'hF, 32'h1);
        wr(1, 16'h1012, 4'hF, 32'h2); step();
        rd(0, 16'h0E00, 32'h4);
        rd(1, 16'h1012, 32'h2); step();
        wr(0, 16'h1010, 4'h1, 32'hAA);
        wr(1, 16'h1010, 4'hF, 32'hBBBBBBBB); step();
        rd(0, 16'h1010, 32'h000000AA);
        rd(1, 16'h0E00, 32'h5); step();
        wr(1, 16'h0500, 4'hF, 32'h55);
        wr(0, 16'h0500, 4'hF, 32'h66); step();
        rd(1, 16'h0500, 32'h66);
        rd(0, 16'h0E00, 32'h6); step();

        // read-first
        wr(0, 16'h1020, 4'hF, 32'h5); step();
        wr(0, 16'h1020, 4'hF, 32'h9);
        rd(1, 16'h1020, 32'h5);
        rd(3, 16'h1020, 32'h5); step();
        rd(1, 16'h1020, 32'h9); step();
        wr(1, 16'h0300, 4'hF, 32'h77);
        rd(0, 16'h0300, 32'hA5A50003); step();
        rd(0, 16'h0300, 32'h77); step();

        // errors
        rd(0, 16'h0002, 32'h0, 1'b1); step();
        wr(1, 16'h0E00, 4'hF, 32'hFFFF, 1'b1); step();
        rd(0, 16'h0E00, 32'h6); step();
        rd(0, 16'h2000, 32'h0, 1'b1);
        rd(1, 16'h0FFF, 32'h0, 1'b1); step();
        wr(0, 16'h0002, 4'hF, 32'h1, 1'b1);
        wr(1, 16'h1FFF, 4'hF, 32'hCAFE0000); step();
        rd(0, 16'h1FFF, 32'hCAFE0000);
        rd(1, 16'h0D01, 32'h0, 1'b1); step();
        rd(0, 16'h0D00, 32'hA5A5000D);
        rd(1, 16'h0F00, 32'h0, 1'b1); step();
        repeat (5) step();

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < np[d]; p++) begin
                check(tg("drain", d, p), 64'(q[d*4+p].size()), 64'h0);
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end
endmodule
